// File: rtl/serial_sub8.sv
// serial_sub8
// Bit-serial 8-bit subtractor: diff = a - b - bin (mod 256), one bit per
// clock, LSB first, through a single full-subtractor cell.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst    in   1  synchronous active-high reset
//   start  in   1  request, honoured only in IDLE or DONE
//   a      in   8  minuend, captured on the accepting edge
//   b      in   8  subtrahend, captured on the accepting edge
//   bin    in   1  borrow-in, captured on the accepting edge
//   busy   out  1  high while bits are being computed (RUN)
//   done   out  1  single-cycle completion pulse (DONE)
//   diff   out  8  registered difference
//   bout   out  1  borrow-out of bit 7 (unsigned a < b + bin)
//   zero   out  1  diff == 0
//   ovf    out  1  signed overflow of the subtraction
module serial_sub8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  output logic       busy,
  output logic       done,
  output logic [7:0] diff,
  output logic       bout,
  output logic       zero,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_reg, state_next;

  // Latched operands and serial working state
  logic [7:0] a_reg, a_next;
  logic [7:0] b_reg, b_next;
  logic [7:0] res_reg, res_next;
  logic [2:0] idx_reg, idx_next;
  logic       br_reg, br_next;

  // Result registers, written only when the last bit completes
  logic [7:0] diff_reg, diff_next;
  logic       bout_reg, bout_next;
  logic       zero_reg, zero_next;
  logic       ovf_reg, ovf_next;

  // Full-subtractor cell operating on the currently indexed bit
  logic       a_bit, b_bit, d_bit, borrow_bit;
  logic [7:0] bit_sel;
  logic [7:0] res_upd;

  assign a_bit      = a_reg[idx_reg];
  assign b_bit      = b_reg[idx_reg];
  assign d_bit      = a_bit ^ b_bit ^ br_reg;
  assign borrow_bit = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_reg);

  // One-hot select of the result bit being written this cycle
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_sel
      assign bit_sel[gi] = (idx_reg == 3'(gi));
    end
  endgenerate

  // Result register with the current bit replaced by the cell output;
  // at idx 7 this is the complete difference, used for the flags too.
  assign res_upd = (res_reg & ~bit_sel) | ({8{d_bit}} & bit_sel);

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    res_next   = res_reg;
    idx_next   = idx_reg;
    br_next    = br_reg;
    diff_next  = diff_reg;
    bout_next  = bout_reg;
    zero_next  = zero_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      IDLE, DONE: begin
        // DONE accepts a new request exactly like IDLE, giving
        // back-to-back operation with start held high.
        if (start) begin
          a_next     = a;
          b_next     = b;
          br_next    = bin;
          idx_next   = 3'd0;
          res_next   = 8'h00;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end

      RUN: begin
        res_next = res_upd;
        br_next  = borrow_bit;
        if (idx_reg == 3'd7) begin
          state_next = DONE;
          diff_next  = res_upd;
          bout_next  = borrow_bit;
          zero_next  = (res_upd == 8'h00);
          // Overflow only possible when operand signs differ and the
          // result sign departs from the minuend's sign.
          ovf_next   = (a_reg[7] ^ b_reg[7]) & (res_upd[7] ^ a_reg[7]);
        end else begin
          idx_next = idx_reg + 3'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= 8'h00;
      b_reg     <= 8'h00;
      res_reg   <= 8'h00;
      idx_reg   <= 3'd0;
      br_reg    <= 1'b0;
      diff_reg  <= 8'h00;
      bout_reg  <= 1'b0;
      zero_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      res_reg   <= res_next;
      idx_reg   <= idx_next;
      br_reg    <= br_next;
      diff_reg  <= diff_next;
      bout_reg  <= bout_next;
      zero_reg  <= zero_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Status decoded straight from the state register, so busy and done
  // are mutually exclusive and done lasts exactly one cycle.
  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign diff = diff_reg;
  assign bout = bout_reg;
  assign zero = zero_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_sub8.sv
// Testbench for serial_sub8: directed vectors with hand-computed results.
// The driver pushes expected results into a queue; a negedge monitor pops
// and compares on every done pulse and checks result hold in between.
module tb_serial_sub8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       bin = 1'b0;
  logic       busy, done;
  logic [7:0] diff;
  logic       bout, zero, ovf;

  serial_sub8 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       zero;
    logic       ovf;
    int         start_cyc;
  } exp_t;

  exp_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rst_q = 1'b1;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic [7:0] last_diff = 8'h00;
  logic       last_bout = 1'b0, last_zero = 1'b0, last_ovf = 1'b0;
  logic       prev_done = 1'b0;
  int         busy_cnt = 0;

  always @(negedge clk) begin
    if (rst_q) begin
      chk("reset_outputs", {busy, done, diff, bout, zero, ovf}, 32'h0);
      last_diff = 8'h00; last_bout = 1'b0; last_zero = 1'b0; last_ovf = 1'b0;
      busy_cnt  = 0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("diff", diff, e.diff);
        chk("bout", bout, e.bout);
        chk("zero", zero, e.zero);
        chk("ovf", ovf, e.ovf);
        chk("latency", cyc - e.start_cyc, 8);
        chk("busy_cycles", busy_cnt, 8);
        $display("done: diff=%02h bout=%0d zero=%0d ovf=%0d at cycle %0d (started %0d)",
                 diff, bout, zero, ovf, cyc, e.start_cyc);
        last_diff = e.diff; last_bout = e.bout; last_zero = e.zero; last_ovf = e.ovf;
      end
      chk("busy_in_done", busy, 0);
      chk("done_single", prev_done, 0);
      busy_cnt = 0;
    end else begin
      chk("hold", {diff, bout, zero, ovf}, {last_diff, last_bout, last_zero, last_ovf});
      if (busy) busy_cnt++;
    end
    prev_done = done;
  end

  // ---------------- driver ----------------
  task automatic wait_idle();
    for (int n = 0; n < 40 && busy; n++) begin
      @(posedge clk); #1;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [7:0] va, input logic [7:0] vb, input logic vbin,
                       input logic [7:0] ed, input logic eb, input logic ez, input logic eo);
    exp_t e;
    wait_idle();
    start = 1'b1; a = va; b = vb; bin = vbin;
    @(posedge clk); #1;
    e.diff = ed; e.bout = eb; e.zero = ez; e.ovf = eo; e.start_cyc = cyc;
    exp_q.push_back(e);
    start = 1'b0;
    $display("issue: a=%02h b=%02h bin=%0d expect diff=%02h bout=%0d zero=%0d ovf=%0d",
             va, vb, vbin, ed, eb, ez, eo);
  endtask

  // Back-to-back vectors: a, b, bin, diff, bout, zero, ovf
  logic [7:0] bb_a   [3] = '{8'hA5, 8'h12, 8'hC8};
  logic [7:0] bb_b   [3] = '{8'h5A, 8'h34, 8'hC8};
  logic       bb_bin [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] bb_d   [3] = '{8'h4B, 8'hDD, 8'h00};
  logic       bb_bo  [3] = '{1'b0, 1'b1, 1'b0};
  logic       bb_z   [3] = '{1'b0, 1'b0, 1'b1};
  logic       bb_o   [3] = '{1'b1, 1'b0, 1'b0};

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    issue(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
    issue(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1);
    issue(8'h3C, 8'h3B, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);

    // start held high; operands scrambled on every non-accepting edge
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      exp_t e;
      start = 1'b1; a = bb_a[j]; b = bb_b[j]; bin = bb_bin[j];
      @(posedge clk); #1;
      e.diff = bb_d[j]; e.bout = bb_bo[j]; e.zero = bb_z[j]; e.ovf = bb_o[j];
      e.start_cyc = cyc;
      exp_q.push_back(e);
      $display("issue b2b: a=%02h b=%02h bin=%0d expect diff=%02h", bb_a[j], bb_b[j], bb_bin[j], bb_d[j]);
      if (j == 2) start = 1'b0;
      for (int k = 0; k < 8; k++) begin
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        @(posedge clk); #1;
      end
    end

    // Abort mid-RUN with a one-cycle reset; no result is expected
    wait_idle();
    start = 1'b1; a = 8'h10; b = 8'h01; bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    $display("issue abort: a=10 b=01 bin=0, reset 4 cycles later");
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", {busy, done}, 2'b00);
    @(posedge clk); #1;

    issue(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);

    repeat (14) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
